// File: rtl/parking_pkg.sv
// Shared types and timer sizing for the parking gate arbiter.
// The optional PARK_EXIT_PRIORITY_EN build is handled in the top module.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PW,
    OPEN_IN,
    OPEN_OUT,
    LOCKOUT
  } park_state_t;

  typedef enum logic {
    LANE_ENTRY,
    LANE_EXIT
  } lane_t;

  localparam int PW_TIMEOUT_DEF     = 32;
  localparam int HOLD_CYCLES_DEF    = 16;
  localparam int LOCKOUT_CYCLES_DEF = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One extra bit so the largest load value always fits.
  function automatic int tmr_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c)) + 1;
  endfunction

  localparam int TMR_W = tmr_width(PW_TIMEOUT_DEF, HOLD_CYCLES_DEF, LOCKOUT_CYCLES_DEF);

endpackage

// File: rtl/parking_timer.sv
// Loadable down-counter shared by the password, hold and lockout phases.
// expire is high while the count is 1, so a load of N gives an N-cycle phase.
module parking_timer
  import parking_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shares one barrier gate between entrance and exit lanes, checks the entry password
// and tracks occupancy. Define PARK_EXIT_PRIORITY_EN to make exit always win ties.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int         CAPACITY       = 8,
  parameter int         CNT_W          = 4,
  parameter logic [1:0] PASS_1         = 2'b01,
  parameter logic [1:0] PASS_2         = 2'b10,
  parameter int         PW_TIMEOUT     = 32,
  parameter int         HOLD_CYCLES    = 16,
  parameter int         MAX_TRIES      = 3,
  parameter int         LOCKOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_entry,
  input  logic             req_exit,
  input  logic [1:0]       password_1,
  input  logic [1:0]       password_2,
  input  logic             pw_valid,
  input  logic             car_passed,
  output logic             gate_open,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic             green_led,
  output logic             red_led,
  output logic             alarm,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full
);

  localparam int TW    = tmr_width(PW_TIMEOUT, HOLD_CYCLES, LOCKOUT_CYCLES);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [TW-1:0]    PW_T     = TW'(PW_TIMEOUT);
  localparam logic [TW-1:0]    HOLD_T   = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0]    LOCK_T   = TW'(LOCKOUT_CYCLES);

  park_state_t      state_q, state_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             gate_open_q, gate_open_d;
  logic             grant_entry_q, grant_entry_d;
  logic             grant_exit_q, grant_exit_d;
  logic             green_led_q, green_led_d;
  logic             red_led_q, red_led_d;
  logic             alarm_q, alarm_d;
`ifndef PARK_EXIT_PRIORITY_EN
  lane_t            rr_q, rr_d;
`endif

  logic             entry_ok;
  logic             exit_ok;
  lane_t            win;
  logic             red_pulse;
  logic             full_block;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_expire;

  parking_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign lot_full = (occ_q == CAP_V);
  assign entry_ok = req_entry & ~lot_full;
  assign exit_ok  = req_exit & (occ_q != '0);

  // Lane selection when IDLE; only consulted if at least one lane is eligible.
  always_comb begin
    win = exit_ok ? LANE_EXIT : LANE_ENTRY;
`ifndef PARK_EXIT_PRIORITY_EN
    if (entry_ok && exit_ok) begin
      win = rr_q;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    tries_d    = tries_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    red_pulse  = 1'b0;
    full_block = 1'b0;
`ifndef PARK_EXIT_PRIORITY_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      IDLE: begin
        full_block = req_entry & lot_full;
        if (entry_ok || exit_ok) begin
          tmr_load = 1'b1;
          if (win == LANE_ENTRY) begin
            state_d = WAIT_PW;
            tmr_val = PW_T;
          end else begin
            state_d = OPEN_OUT;
            tmr_val = HOLD_T;
          end
`ifndef PARK_EXIT_PRIORITY_EN
          rr_d = (win == LANE_ENTRY) ? LANE_EXIT : LANE_ENTRY;
`endif
        end
      end
      WAIT_PW: begin
        // A strobe in the expiry cycle still counts.
        if (pw_valid) begin
          tmr_load = 1'b1;
          if (password_1 == PASS_1 && password_2 == PASS_2) begin
            state_d = OPEN_IN;
            tries_d = '0;
            tmr_val = HOLD_T;
          end else begin
            red_pulse = 1'b1;
            tries_d   = tries_q + TRY_W'(1);
            if (tries_q >= LAST_TRY) begin
              state_d = LOCKOUT;
              tmr_val = LOCK_T;
            end else begin
              tmr_val = PW_T;
            end
          end
        end else if (tmr_expire) begin
          state_d = IDLE;
        end
      end
      OPEN_IN: begin
        if (car_passed) begin
          state_d = IDLE;
          if (occ_q != CAP_V) begin
            occ_d = occ_q + CNT_W'(1);
          end
        end else if (tmr_expire) begin
          state_d = IDLE;
        end
      end
      OPEN_OUT: begin
        if (car_passed) begin
          state_d = IDLE;
          if (occ_q != '0) begin
            occ_d = occ_q - CNT_W'(1);
          end
        end else if (tmr_expire) begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (tmr_expire) begin
          state_d = IDLE;
          tries_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    gate_open_d   = (state_d == OPEN_IN) || (state_d == OPEN_OUT);
    green_led_d   = (state_d == OPEN_IN) || (state_d == OPEN_OUT);
    grant_entry_d = (state_d == WAIT_PW) || (state_d == OPEN_IN);
    grant_exit_d  = (state_d == OPEN_OUT);
    alarm_d       = (state_d == LOCKOUT);
    red_led_d     = red_pulse || full_block || (state_d == LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      occ_q         <= '0;
      tries_q       <= '0;
      gate_open_q   <= 1'b0;
      grant_entry_q <= 1'b0;
      grant_exit_q  <= 1'b0;
      green_led_q   <= 1'b0;
      red_led_q     <= 1'b0;
      alarm_q       <= 1'b0;
`ifndef PARK_EXIT_PRIORITY_EN
      rr_q          <= LANE_EXIT;
`endif
    end else begin
      state_q       <= state_d;
      occ_q         <= occ_d;
      tries_q       <= tries_d;
      gate_open_q   <= gate_open_d;
      grant_entry_q <= grant_entry_d;
      grant_exit_q  <= grant_exit_d;
      green_led_q   <= green_led_d;
      red_led_q     <= red_led_d;
      alarm_q       <= alarm_d;
`ifndef PARK_EXIT_PRIORITY_EN
      rr_q          <= rr_d;
`endif
    end
  end

  assign gate_open   = gate_open_q;
  assign grant_entry = grant_entry_q;
  assign grant_exit  = grant_exit_q;
  assign green_led   = green_led_q;
  assign red_led     = red_led_q;
  assign alarm       = alarm_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: fixed vectors, corner-case sequences
// and randomized traffic against a cycle-level behavioural model.
module tb_parking_gate_arbiter;

  localparam int         CAPACITY       = 8;
  localparam int         CNT_W          = 4;
  localparam logic [1:0] PASS_1         = 2'b01;
  localparam logic [1:0] PASS_2         = 2'b10;
  localparam int         PW_TIMEOUT     = 32;
  localparam int         HOLD_CYCLES    = 16;
  localparam int         MAX_TRIES      = 3;
  localparam int         LOCKOUT_CYCLES = 64;
  localparam int         OW             = 7 + CNT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, req_entry, req_exit, pw_valid, car_passed;
  logic [1:0]       password_1, password_2;
  logic             gate_open, grant_entry, grant_exit, green_led, red_led, alarm, lot_full;
  logic [CNT_W-1:0] occupancy;
  logic [OW-1:0]    dut_o;

  parking_gate_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_entry   (req_entry),
    .req_exit    (req_exit),
    .password_1  (password_1),
    .password_2  (password_2),
    .pw_valid    (pw_valid),
    .car_passed  (car_passed),
    .gate_open   (gate_open),
    .grant_entry (grant_entry),
    .grant_exit  (grant_exit),
    .green_led   (green_led),
    .red_led     (red_led),
    .alarm       (alarm),
    .occupancy   (occupancy),
    .lot_full    (lot_full)
  );

  // Output vector: {gate, grant_entry, grant_exit, green, red, alarm, lot_full, occupancy}
  assign dut_o = {gate_open, grant_entry, grant_exit, green_led, red_led, alarm, lot_full, occupancy};

  typedef struct packed {
    logic       rst;
    logic       re;
    logic       rx;
    logic       pv;
    logic [1:0] p1;
    logic [1:0] p2;
    logic       cp;
  } stim_t;

  typedef struct {
    stim_t         s;
    logic [OW-1:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [OW-1:0] exp_q[$];

  // Behavioural model: a phase, cycles left in it, car count, failed tries, tie preference.
  typedef enum int {M_IDLE, M_WAIT, M_IN, M_OUT, M_LOCK} mph_t;
  mph_t m_ph       = M_IDLE;
  int   m_left     = 0;
  int   m_occ      = 0;
  int   m_tries    = 0;
  bit   m_pref_exit = 1'b1;
  bit   m_red      = 1'b0;

  function automatic stim_t mk(input logic rst, input logic re, input logic rx, input logic pv,
                               input logic [1:0] p1, input logic [1:0] p2, input logic cp);
    stim_t s;
    s.rst = rst; s.re = re; s.rx = rx; s.pv = pv; s.p1 = p1; s.p2 = p2; s.cp = cp;
    return s;
  endfunction

  function automatic logic [OW-1:0] m_out();
    logic is_open, is_lock;
    is_open = (m_ph == M_IN) || (m_ph == M_OUT);
    is_lock = (m_ph == M_LOCK);
    return {is_open, (m_ph == M_WAIT) || (m_ph == M_IN), m_ph == M_OUT, is_open,
            m_red || is_lock, is_lock, m_occ == CAPACITY, CNT_W'(m_occ)};
  endfunction

  function automatic void model_step(input stim_t s);
    bit e_ok, x_ok, take_exit;
    m_red = 1'b0;
    if (s.rst) begin
      m_ph = M_IDLE; m_occ = 0; m_tries = 0; m_pref_exit = 1'b1;
    end else begin
      case (m_ph)
        M_IDLE: begin
          e_ok = s.re && (m_occ < CAPACITY);
          x_ok = s.rx && (m_occ > 0);
          if (s.re && m_occ == CAPACITY) m_red = 1'b1;
`ifdef PARK_EXIT_PRIORITY_EN
          take_exit = x_ok;
`else
          take_exit = x_ok && (!e_ok || m_pref_exit);
`endif
          if (take_exit) begin
            m_ph = M_OUT; m_left = HOLD_CYCLES; m_pref_exit = 1'b0;
          end else if (e_ok) begin
            m_ph = M_WAIT; m_left = PW_TIMEOUT; m_pref_exit = 1'b1;
          end
        end
        M_WAIT: begin
          if (s.pv) begin
            if (s.p1 == PASS_1 && s.p2 == PASS_2) begin
              m_tries = 0; m_ph = M_IN; m_left = HOLD_CYCLES;
            end else begin
              m_tries++; m_red = 1'b1;
              if (m_tries >= MAX_TRIES) begin
                m_ph = M_LOCK; m_left = LOCKOUT_CYCLES;
              end else begin
                m_left = PW_TIMEOUT;
              end
            end
          end else begin
            m_left--;
            if (m_left == 0) m_ph = M_IDLE;
          end
        end
        M_IN, M_OUT: begin
          if (s.cp) begin
            if (m_ph == M_IN) m_occ = (m_occ < CAPACITY) ? m_occ + 1 : m_occ;
            else              m_occ = (m_occ > 0) ? m_occ - 1 : m_occ;
            m_ph = M_IDLE;
          end else begin
            m_left--;
            if (m_left == 0) m_ph = M_IDLE;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_tries = 0; m_ph = M_IDLE;
          end
        end
      endcase
    end
    exp_q.push_back(m_out());
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Drive on the falling edge, step the model on the rising edge, compare 1 ns later.
  task automatic tick(input stim_t s);
    logic [OW-1:0] e;
    @(negedge clk);
    reset = s.rst; req_entry = s.re; req_exit = s.rx; pw_valid = s.pv;
    password_1 = s.p1; password_2 = s.p2; car_passed = s.cp;
    @(posedge clk);
    model_step(s);
    #1;
    e = exp_q.pop_front();
    check("model", dut_o, e);
  endtask

  task automatic do_reset();
    tick(mk(1, 0, 0, 0, 2'd0, 2'd0, 0));
  endtask

  task automatic park_one();
    tick(mk(0, 1, 0, 0, 2'd0, 2'd0, 0));
    tick(mk(0, 0, 0, 1, PASS_1, PASS_2, 0));
    tick(mk(0, 0, 0, 0, 2'd0, 2'd0, 1));
  endtask

  vec_t vecs[15];

  initial begin
    int cnt;
    bit [2:0] order, exp_order;
    stim_t s;

    reset = 1'b1; req_entry = 1'b0; req_exit = 1'b0; pw_valid = 1'b0;
    password_1 = 2'd0; password_2 = 2'd0; car_passed = 1'b0;

    // Fixed vectors: entry, exit, idle car_passed, wrong then right password, reset in OPEN_IN.
    vecs[0]  = '{mk(1, 0, 0, 0, 2'd0, 2'd0, 0), {7'b0000000, 4'd0}};
    vecs[1]  = '{mk(0, 0, 1, 0, 2'd0, 2'd0, 0), {7'b0000000, 4'd0}};
    vecs[2]  = '{mk(0, 1, 0, 0, 2'd0, 2'd0, 0), {7'b0100000, 4'd0}};
    vecs[3]  = '{mk(0, 0, 0, 1, 2'd1, 2'd2, 0), {7'b1101000, 4'd0}};
    vecs[4]  = '{mk(0, 0, 0, 0, 2'd0, 2'd0, 1), {7'b0000000, 4'd1}};
    vecs[5]  = '{mk(0, 0, 1, 0, 2'd0, 2'd0, 0), {7'b1011000, 4'd1}};
    vecs[6]  = '{mk(0, 0, 0, 0, 2'd0, 2'd0, 1), {7'b0000000, 4'd0}};
    vecs[7]  = '{mk(0, 0, 0, 0, 2'd0, 2'd0, 1), {7'b0000000, 4'd0}};
    vecs[8]  = '{mk(0, 1, 0, 0, 2'd0, 2'd0, 0), {7'b0100000, 4'd0}};
    vecs[9]  = '{mk(0, 0, 0, 1, 2'd3, 2'd3, 0), {7'b0100100, 4'd0}};
    vecs[10] = '{mk(0, 0, 0, 0, 2'd0, 2'd0, 0), {7'b0100000, 4'd0}};
    vecs[11] = '{mk(0, 0, 0, 1, 2'd1, 2'd2, 0), {7'b1101000, 4'd0}};
    vecs[12] = '{mk(1, 0, 0, 0, 2'd0, 2'd0, 0), {7'b0000000, 4'd0}};
    vecs[13] = '{mk(0, 1, 1, 0, 2'd0, 2'd0, 0), {7'b0100000, 4'd0}};
    vecs[14] = '{mk(1, 0, 0, 0, 2'd0, 2'd0, 0), {7'b0000000, 4'd0}};
    for (int i = 0; i < 15; i++) begin
      tick(vecs[i].s);
      check($sformatf("vec%0d", i), dut_o, vecs[i].exp);
    end

    // Lockout: three wrong strobes, alarm for LOCKOUT_CYCLES with entry held, tries cleared.
    do_reset();
    tick(mk(0, 1, 0, 0, 2'd0, 2'd0, 0));
    tick(mk(0, 0, 0, 1, 2'd3, 2'd3, 0));
    check_val("wrong_pw_red", int'(red_led), 1);
    tick(mk(0, 0, 0, 0, 2'd0, 2'd0, 0));
    check_val("red_pulse_end", int'(red_led), 0);
    tick(mk(0, 0, 0, 1, 2'd3, 2'd3, 0));
    tick(mk(0, 0, 0, 0, 2'd0, 2'd0, 0));
    tick(mk(0, 0, 0, 1, 2'd3, 2'd3, 0));
    cnt = 0;
    while (alarm === 1'b1 && cnt < 200) begin
      cnt++;
      tick(mk(0, 1, 0, 0, 2'd0, 2'd0, 0));
    end
    check_val("lockout_len", cnt, LOCKOUT_CYCLES);
    tick(mk(0, 1, 0, 0, 2'd0, 2'd0, 0));
    check_val("grant_after_lock", int'(grant_entry), 1);
    tick(mk(0, 0, 0, 1, 2'd0, 2'd0, 0));
    tick(mk(0, 0, 0, 1, 2'd2, 2'd1, 0));
    tick(mk(0, 0, 0, 1, PASS_1, PASS_2, 0));
    check_val("tries_cleared", int'(gate_open), 1);
    tick(mk(0, 0, 0, 0, 2'd0, 2'd0, 1));

    // Password timeout, then gate hold timeout, then reset while open.
    do_reset();
    tick(mk(0, 1, 0, 0, 2'd0, 2'd0, 0));
    cnt = 0;
    while (grant_entry === 1'b1 && cnt < 100) begin
      cnt++;
      tick(mk(0, 0, 0, 0, 2'd0, 2'd0, 0));
    end
    check_val("pw_timeout_len", cnt, PW_TIMEOUT);
    tick(mk(0, 1, 0, 0, 2'd0, 2'd0, 0));
    tick(mk(0, 0, 0, 1, PASS_1, PASS_2, 0));
    cnt = 0;
    while (gate_open === 1'b1 && cnt < 100) begin
      cnt++;
      tick(mk(0, 0, 0, 0, 2'd0, 2'd0, 0));
    end
    check_val("hold_len", cnt, HOLD_CYCLES);
    check_val("hold_occ", int'(occupancy), 0);
    park_one();
    tick(mk(0, 1, 0, 0, 2'd0, 2'd0, 0));
    tick(mk(0, 0, 0, 1, PASS_1, PASS_2, 0));
    tick(mk(1, 0, 0, 0, 2'd0, 2'd0, 1));
    check("reset_in_open", dut_o, '0);

    // Fill the lot, then entry is refused while a simultaneous exit is granted.
    do_reset();
    for (int i = 0; i < CAPACITY; i++) park_one();
    check_val("lot_full", int'(lot_full), 1);
    tick(mk(0, 1, 0, 0, 2'd0, 2'd0, 0));
    check_val("full_red", int'(red_led), 1);
    check_val("full_no_grant", int'(grant_entry), 0);
    tick(mk(0, 1, 1, 0, 2'd0, 2'd0, 0));
    check_val("full_exit_grant", int'(grant_exit), 1);
    tick(mk(0, 1, 1, 0, 2'd0, 2'd0, 1));
    check_val("full_after_exit", int'(occupancy), CAPACITY - 1);

    // Both lanes held with the lot half full.
    do_reset();
    for (int i = 0; i < CAPACITY / 2; i++) park_one();
    order = '0;
    for (int g = 0; g < 3; g++) begin
      tick(mk(0, 1, 1, 0, 2'd0, 2'd0, 0));
      order[g] = grant_exit;
      if (grant_exit === 1'b1) begin
        tick(mk(0, 1, 1, 0, 2'd0, 2'd0, 1));
      end else begin
        tick(mk(0, 1, 1, 1, PASS_1, PASS_2, 0));
        tick(mk(0, 1, 1, 0, 2'd0, 2'd0, 1));
      end
    end
`ifdef PARK_EXIT_PRIORITY_EN
    exp_order = 3'b111;
`else
    exp_order = 3'b101;
`endif
    check_val("tie_order", int'(order), int'(exp_order));

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(0, 599) == 0);
      s.re  = 1'($urandom_range(0, 1));
      s.rx  = 1'($urandom_range(0, 1));
      s.pv  = ($urandom_range(0, 3) == 0);
      s.p1  = $urandom_range(0, 1) ? PASS_1 : 2'($urandom_range(0, 3));
      s.p2  = $urandom_range(0, 1) ? PASS_2 : 2'($urandom_range(0, 3));
      s.cp  = ($urandom_range(0, 3) == 0);
      tick(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
